pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multi-context program-counter sequencer; successor to the single shared PC, one PC per warp context. Each context has its own PC, a NZP-conditional branch, a call/return stack of configurable depth, a halt state and a fault state. It sits between the scheduler (which selects the context and issues the advance strobe) and instruction fetch (which reads `pc_rd`).

Parameters:
- ADDR_BITS, 8, program memory address width.
- NUM_CTX, 4, number of independent PC contexts (warps), >=1.
- STACK_DEPTH, 4, return-stack entries per context, >=1.
- CTX_W, $clog2(NUM_CTX) min 1, context select width (derived, localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; launches all contexts at start_pc.
- start_pc  in  ADDR_BITS  launch address.
- ctx_sel  in  CTX_W  context addressed by advance and pc_rd.
- advance  in  1  apply op to selected context this cycle.
- op  in  3  pc_op_t: SEQ, BRANCH, CALL, RET, HALT.
- nzp_mask  in  3  instruction condition bits {N,Z,P}.
- nzp_flags  in  3  selected context's current {N,Z,P} flags.
- target  in  ADDR_BITS  branch/call target.
- pc_rd  out  ADDR_BITS  PC of selected context (combinational read of registered PC).
- running  out  NUM_CTX  per-context state==RUN.
- fault  out  NUM_CTX  per-context sticky fault.
- done  out  1  launched and no context in RUN.

Behaviour:
- Reset (async): all PCs 0, all contexts IDLE, stack pointers 0, stack contents don't-care.
- Reset outputs: running=0, fault=0, done=0, launched flag 0. Reset mid-operation aborts everything immediately.
- Context states: IDLE, RUN, HALTED, FAULT.
- start (synchronous), for every context:
  - PC<=start_pc, state<=RUN, SP<=0, fault cleared.
  - launched<=1.
  - start has priority over a same-cycle advance; that advance is dropped.
- advance applies only when ctx_sel<NUM_CTX and the selected context is in RUN. Otherwise it is ignored with no state change.
- Effect of op on selected context, one-cycle latency (new PC visible on pc_rd the cycle after advance):
  - SEQ: PC<=PC+1, modulo 2^ADDR_BITS (wraps max->0).
  - BRANCH: if (nzp_mask & nzp_flags)!=0 then PC<=target, else PC<=PC+1. Mask 000 is never taken; mask 111 is taken if any flag is set.
  - CALL: if SP<STACK_DEPTH then push PC+1 (wrapped), SP++, PC<=target. If SP==STACK_DEPTH (full): state<=FAULT, PC and stack unchanged.
  - RET: if SP>0 then PC<=top entry, SP--. If SP==0 (empty): state<=FAULT, PC unchanged.
  - HALT: state<=HALTED, PC unchanged.
  - Reserved op encodings: treated as SEQ.
- Other contexts are never affected by an advance to a different context.
- fault[i]=1 while context i is in FAULT. It is cleared only by start or reset.
- done = launched && no context in RUN. Registered-state-derived, so it asserts the cycle after the last context leaves RUN. Cleared by start.
- pc_rd with ctx_sel>=NUM_CTX returns 0.
- HALTED and FAULT contexts hold their PC, readable for debug.

Decomposition:
- Shared package gpu_pkg gets:
  - pc_op_t enum (3-bit: SEQ=0, BRANCH=1, CALL=2, RET=3, HALT=4).
  - pc_ctx_state_t enum.
  - NZP bit-index constants (N=2, Z=1, P=0).
- Sub-module pc_ret_stack: per-context LIFO (DEPTH, WIDTH params; push/pop/full/empty/top). Instantiated NUM_CTX times in a generate loop; the top level holds PCs, state FSMs and the done logic.

Test Plan:
- Reset then start with start_pc=0x10 -> all PCs 0x10, running=1111, done=0. Then 3×SEQ on ctx2 -> pc_rd(ctx2)=0x13, ctx0 still 0x10.
- BRANCH on ctx1 at PC=0x20, target=0x40:
  - mask=010, flags=010 -> PC=0x40.
  - mask=100, flags=001 -> PC=0x21.
  - mask=000 -> never taken.
- ADDR_BITS=8, SEQ at PC=0xFF -> PC=0x00. CALL at PC=0xFF, target=0x05 -> later RET returns to 0x00.
- STACK_DEPTH=4: 4 nested CALLs then 4 RETs on ctx0 -> PCs unwind in LIFO order. 5th CALL -> fault[0]=1, running[0]=0, PC unchanged. RET on an empty stack of ctx3 -> fault[3]=1.
- HALT each context in turn -> done asserts exactly one cycle after the last HALT. An advance to a halted context leaves its PC unchanged. start in the same cycle as an advance -> all PCs=start_pc, done=0.
- Assert reset mid-run with nonzero PCs -> next observation: PCs 0, running=0, fault=0, done=0. An advance with ctx_sel>=NUM_CTX (NUM_CTX=3) is ignored and pc_rd reads 0.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and constants for the GPU front-end blocks.
package gpu_pkg;

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_CALL   = 3'd2,
        OP_RET    = 3'd3,
        OP_HALT   = 3'd4
    } pc_op_t;

    typedef enum logic [1:0] {
        CTX_IDLE   = 2'd0,
        CTX_RUN    = 2'd1,
        CTX_HALTED = 2'd2,
        CTX_FAULT  = 2'd3
    } pc_ctx_state_t;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    // A single context still needs a one-bit select.
    function automatic int ctx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: scheduler/fetch-facing bus of the multi-context PC sequencer.
interface pc_sequencer_if
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int NUM_CTX   = 4
);
    localparam int CTX_W = ctx_w(NUM_CTX);

    logic                 start;
    logic [ADDR_BITS-1:0] start_pc;
    logic [CTX_W-1:0]     ctx_sel;
    logic                 advance;
    logic [2:0]           op;
    logic [2:0]           nzp_mask;
    logic [2:0]           nzp_flags;
    logic [ADDR_BITS-1:0] target;
    logic [ADDR_BITS-1:0] pc_rd;
    logic [NUM_CTX-1:0]   running;
    logic [NUM_CTX-1:0]   fault;
    logic                 done;

    modport master (
        output start, start_pc, ctx_sel, advance, op, nzp_mask, nzp_flags, target,
        input  pc_rd, running, fault, done
    );

    modport slave (
        input  start, start_pc, ctx_sel, advance, op, nzp_mask, nzp_flags, target,
        output pc_rd, running, fault, done
    );

endinterface

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: per-context LIFO of return addresses; entries are not reset.
module pc_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp_q, sp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full  = sp_q == SPW'(DEPTH);
    assign empty = sp_q == '0;
    assign top   = empty ? '0 : mem_q[IW'(sp_q - SPW'(1))];

    always_comb begin
        sp_d = clr ? '0 : (push && !full) ? sp_q + SPW'(1) : (pop && !empty) ? sp_q - SPW'(1) : sp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sp_q <= '0;
        else sp_q <= sp_d;
    end

    always_ff @(posedge clk) begin
        if (push && !full && !clr) mem_q[IW'(sp_q)] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: one PC, NZP branch, return stack and run/halt/fault state per warp context.
module pc_sequencer
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int NUM_CTX     = 4,
    parameter int STACK_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int CTX_W = ctx_w(NUM_CTX);

    logic [NUM_CTX-1:0][ADDR_BITS-1:0] pc_all;
    logic [NUM_CTX-1:0] run_v, flt_v;
    logic [ADDR_BITS-1:0] pc_rd_c;
    logic launched_q, launched_d, adv_ok, taken;

    // start wins over a same-cycle advance.
    assign adv_ok = bus.advance && !bus.start && int'(bus.ctx_sel) < NUM_CTX;
    assign taken  = |(bus.nzp_mask & bus.nzp_flags);

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
        logic [ADDR_BITS-1:0] pc_q, pc_d, top, pc_inc;
        pc_ctx_state_t st_q, st_d;
        logic hit, full, empty;
        assign pc_inc = pc_q + 1'b1;
        assign hit    = adv_ok && bus.ctx_sel == CTX_W'(g) && st_q == CTX_RUN;
        pc_ret_stack #(.DEPTH(STACK_DEPTH), .WIDTH(ADDR_BITS)) u_stack (
            .clk   (clk),
            .reset (reset),
            .clr   (bus.start),
            .push  (hit && bus.op == OP_CALL),
            .pop   (hit && bus.op == OP_RET),
            .din   (pc_inc),
            .top   (top),
            .full  (full),
            .empty (empty)
        );
        always_comb begin
            pc_d = pc_q;
            st_d = st_q;
            if (bus.start) begin
                pc_d = bus.start_pc;
                st_d = CTX_RUN;
            end else if (hit) begin
                case (bus.op)
                    OP_BRANCH: pc_d = taken ? bus.target : pc_inc;
                    OP_CALL:   if (full) st_d = CTX_FAULT; else pc_d = bus.target;
                    OP_RET:    if (empty) st_d = CTX_FAULT; else pc_d = top;
                    OP_HALT:   st_d = CTX_HALTED;
                    default:   pc_d = pc_inc;
                endcase
            end
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pc_q <= '0;
                st_q <= CTX_IDLE;
            end else begin
                pc_q <= pc_d;
                st_q <= st_d;
            end
        end
        assign pc_all[g] = pc_q;
        assign run_v[g]  = st_q == CTX_RUN;
        assign flt_v[g]  = st_q == CTX_FAULT;
    end

    always_comb begin
        pc_rd_c = '0;
        for (int i = 0; i < NUM_CTX; i++) if (int'(bus.ctx_sel) == i) pc_rd_c = pc_all[i];
    end

    assign launched_d = bus.start ? 1'b1 : launched_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) launched_q <= 1'b0;
        else launched_q <= launched_d;
    end

    assign bus.pc_rd   = pc_rd_c;
    assign bus.running = run_v;
    assign bus.fault   = flt_v;
    assign bus.done    = launched_q && run_v == '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer, 4-context and 3-context builds.
module tb_pc_sequencer;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_BITS(8), .NUM_CTX(4)) m0 ();
    pc_sequencer_if #(.ADDR_BITS(8), .NUM_CTX(3)) m1 ();

    pc_sequencer #(.ADDR_BITS(8), .NUM_CTX(4), .STACK_DEPTH(4)) u0 (.clk(clk), .reset(reset), .bus(m0.slave));
    pc_sequencer #(.ADDR_BITS(8), .NUM_CTX(3), .STACK_DEPTH(4)) u1 (.clk(clk), .reset(reset), .bus(m1.slave));

    task automatic idle_inputs();
        m0.start = 0; m0.start_pc = 0; m0.ctx_sel = 0; m0.advance = 0;
        m0.op = 0; m0.nzp_mask = 0; m0.nzp_flags = 0; m0.target = 0;
        m1.start = 0; m1.start_pc = 0; m1.ctx_sel = 0; m1.advance = 0;
        m1.op = 0; m1.nzp_mask = 0; m1.nzp_flags = 0; m1.target = 0;
    endtask

    task automatic adv0(input logic [1:0] c, input logic [2:0] o, input logic [2:0] m,
                        input logic [2:0] f, input logic [7:0] t);
        m0.ctx_sel = c; m0.op = o; m0.nzp_mask = m; m0.nzp_flags = f; m0.target = t;
        m0.advance = 1;
        @(posedge clk); #1;
        m0.advance = 0;
    endtask

    task automatic start0(input logic [7:0] a);
        m0.start = 1; m0.start_pc = a;
        @(posedge clk); #1;
        m0.start = 0;
    endtask

    task automatic rd0(input logic [1:0] c, output logic [7:0] p);
        m0.ctx_sel = c;
        #1 p = m0.pc_rd;
    endtask

    task automatic test_reset();
        logic [7:0] p;
        rd0(0, p);
        n_cmp++; if (p !== 8'h00) begin n_bad++; $display("FAIL reset_pc got %h want 00", p); end
        n_cmp++; if (m0.running !== 4'b0000) begin n_bad++; $display("FAIL reset_running got %b want 0000", m0.running); end
        n_cmp++; if (m0.fault !== 4'b0000) begin n_bad++; $display("FAIL reset_fault got %b want 0000", m0.fault); end
        n_cmp++; if (m0.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", m0.done); end
    endtask

    task automatic test_start_seq();
        logic [7:0] p;
        start0(8'h10);
        for (int i = 0; i < 4; i++) begin
            rd0(2'(i), p);
            n_cmp++; if (p !== 8'h10) begin n_bad++; $display("FAIL start_pc ctx%0d got %h want 10", i, p); end
        end
        n_cmp++; if (m0.running !== 4'b1111) begin n_bad++; $display("FAIL start_running got %b want 1111", m0.running); end
        n_cmp++; if (m0.done !== 1'b0) begin n_bad++; $display("FAIL start_done got %b want 0", m0.done); end
        adv0(2, OP_SEQ, 0, 0, 0);
        adv0(2, OP_SEQ, 0, 0, 0);
        adv0(2, 3'd6, 0, 0, 8'hAA);
        rd0(2, p);
        n_cmp++; if (p !== 8'h13) begin n_bad++; $display("FAIL seq_ctx2 got %h want 13", p); end
        rd0(0, p);
        n_cmp++; if (p !== 8'h10) begin n_bad++; $display("FAIL seq_ctx0_untouched got %h want 10", p); end
    endtask

    task automatic test_branch();
        logic [7:0] p;
        adv0(1, OP_BRANCH, 3'b111, 3'b001, 8'h20);
        rd0(1, p);
        n_cmp++; if (p !== 8'h20) begin n_bad++; $display("FAIL br_setup got %h want 20", p); end
        adv0(1, OP_BRANCH, 3'b010, 3'b010, 8'h40);
        rd0(1, p);
        n_cmp++; if (p !== 8'h40) begin n_bad++; $display("FAIL br_z_taken got %h want 40", p); end
        adv0(1, OP_BRANCH, 3'b111, 3'b100, 8'h20);
        adv0(1, OP_BRANCH, 3'b100, 3'b001, 8'h40);
        rd0(1, p);
        n_cmp++; if (p !== 8'h21) begin n_bad++; $display("FAIL br_not_taken got %h want 21", p); end
        adv0(1, OP_BRANCH, 3'b000, 3'b111, 8'h40);
        rd0(1, p);
        n_cmp++; if (p !== 8'h22) begin n_bad++; $display("FAIL br_mask0 got %h want 22", p); end
    endtask

    task automatic test_wrap();
        logic [7:0] p;
        adv0(2, OP_BRANCH, 3'b001, 3'b001, 8'hFF);
        adv0(2, OP_SEQ, 0, 0, 0);
        rd0(2, p);
        n_cmp++; if (p !== 8'h00) begin n_bad++; $display("FAIL wrap_seq got %h want 00", p); end
        adv0(2, OP_BRANCH, 3'b001, 3'b001, 8'hFF);
        adv0(2, OP_CALL, 0, 0, 8'h05);
        rd0(2, p);
        n_cmp++; if (p !== 8'h05) begin n_bad++; $display("FAIL wrap_call got %h want 05", p); end
        adv0(2, OP_RET, 0, 0, 0);
        rd0(2, p);
        n_cmp++; if (p !== 8'h00) begin n_bad++; $display("FAIL wrap_ret got %h want 00", p); end
    endtask

    task automatic test_stack();
        logic [7:0] p;
        logic [7:0] tg [4] = '{8'h30, 8'h40, 8'h50, 8'h60};
        logic [7:0] rt [4] = '{8'h51, 8'h41, 8'h31, 8'h11};
        for (int i = 0; i < 4; i++) begin
            adv0(0, OP_CALL, 0, 0, tg[i]);
            rd0(0, p);
            n_cmp++; if (p !== tg[i]) begin n_bad++; $display("FAIL call%0d got %h want %h", i, p, tg[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            adv0(0, OP_RET, 0, 0, 0);
            rd0(0, p);
            n_cmp++; if (p !== rt[i]) begin n_bad++; $display("FAIL ret%0d got %h want %h", i, p, rt[i]); end
        end
        for (int i = 0; i < 4; i++) adv0(0, OP_CALL, 0, 0, tg[i]);
        adv0(0, OP_CALL, 0, 0, 8'h70);
        rd0(0, p);
        n_cmp++; if (p !== 8'h60) begin n_bad++; $display("FAIL overflow_pc got %h want 60", p); end
        n_cmp++; if (m0.fault !== 4'b0001) begin n_bad++; $display("FAIL overflow_fault got %b want 0001", m0.fault); end
        adv0(3, OP_RET, 0, 0, 0);
        rd0(3, p);
        n_cmp++; if (p !== 8'h10) begin n_bad++; $display("FAIL underflow_pc got %h want 10", p); end
        n_cmp++; if (m0.fault !== 4'b1001) begin n_bad++; $display("FAIL underflow_fault got %b want 1001", m0.fault); end
        n_cmp++; if (m0.running !== 4'b0110) begin n_bad++; $display("FAIL fault_running got %b want 0110", m0.running); end
    endtask

    task automatic test_halt_done();
        logic [7:0] p;
        start0(8'h80);
        n_cmp++; if (m0.fault !== 4'b0000) begin n_bad++; $display("FAIL start_clr_fault got %b want 0000", m0.fault); end
        for (int i = 0; i < 3; i++) begin
            adv0(2'(i), OP_HALT, 0, 0, 0);
            n_cmp++; if (m0.done !== 1'b0) begin n_bad++; $display("FAIL done_early after halt%0d got %b want 0", i, m0.done); end
        end
        adv0(3, OP_HALT, 0, 0, 0);
        n_cmp++; if (m0.done !== 1'b1) begin n_bad++; $display("FAIL done_last got %b want 1", m0.done); end
        n_cmp++; if (m0.running !== 4'b0000) begin n_bad++; $display("FAIL halt_running got %b want 0000", m0.running); end
        adv0(1, OP_SEQ, 0, 0, 0);
        rd0(1, p);
        n_cmp++; if (p !== 8'h80) begin n_bad++; $display("FAIL halted_hold got %h want 80", p); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        start0(8'h55);
        n_cmp++; if (m0.done !== 1'b0) begin n_bad++; $display("FAIL restart_done got %b want 0", m0.done); end
        adv0(0, OP_SEQ, 0, 0, 0);
        rd0(0, p);
        n_cmp++; if (p !== 8'h56) begin n_bad++; $display("FAIL restart_seq got %h want 56", p); end
        m0.start = 1; m0.start_pc = 8'h66;
        adv0(0, OP_SEQ, 0, 0, 0);
        m0.start = 0;
        rd0(0, p);
        n_cmp++; if (p !== 8'h66) begin n_bad++; $display("FAIL collide_ctx0 got %h want 66", p); end
        rd0(1, p);
        n_cmp++; if (p !== 8'h66) begin n_bad++; $display("FAIL collide_ctx1 got %h want 66", p); end
        n_cmp++; if (m0.running !== 4'b1111) begin n_bad++; $display("FAIL collide_running got %b want 1111", m0.running); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p;
        adv0(1, OP_SEQ, 0, 0, 0);
        #2 reset = 1;
        rd0(1, p);
        n_cmp++; if (p !== 8'h00) begin n_bad++; $display("FAIL midreset_pc got %h want 00", p); end
        n_cmp++; if (m0.running !== 4'b0000) begin n_bad++; $display("FAIL midreset_running got %b want 0000", m0.running); end
        n_cmp++; if (m0.done !== 1'b0) begin n_bad++; $display("FAIL midreset_done got %b want 0", m0.done); end
        n_cmp++; if (m0.fault !== 4'b0000) begin n_bad++; $display("FAIL midreset_fault got %b want 0000", m0.fault); end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_out_of_range();
        m1.start = 1; m1.start_pc = 8'h20;
        @(posedge clk); #1;
        m1.start = 0;
        m1.ctx_sel = 2'd3; m1.op = OP_SEQ; m1.advance = 1;
        @(posedge clk); #1;
        m1.advance = 0;
        n_cmp++; if (m1.pc_rd !== 8'h00) begin n_bad++; $display("FAIL oor_pc_rd got %h want 00", m1.pc_rd); end
        for (int i = 0; i < 3; i++) begin
            m1.ctx_sel = 2'(i);
            #1;
            n_cmp++; if (m1.pc_rd !== 8'h20) begin n_bad++; $display("FAIL oor_ctx%0d got %h want 20", i, m1.pc_rd); end
        end
        n_cmp++; if (m1.running !== 3'b111) begin n_bad++; $display("FAIL oor_running got %b want 111", m1.running); end
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 0;
        @(posedge clk); #1;
        test_start_seq();
        test_branch();
        test_wrap();
        test_stack();
        test_halt_done();
        test_back_to_back();
        test_reset_mid();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
